// File: rtl/rr_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM among NUM_REQ readers, with optional
// bounded lock bursts and a registered one-hot read-valid.
module rr_rom_arbiter #(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            lock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          rom_en,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_dout
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] rvalid_q;

   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] others;
   logic [PTR_W-1:0]   idx;
   logic [PTR_W-1:0]   win_idx;
   logic               hold;
   logic               found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         rvalid_q <= gnt;
      end
   end

   always_comb begin
      state_d = StIdle;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = '0;
      if (found) begin
         state_d = lock[win_idx] ? StLocked : StGrant;
         owner_d = win_idx;
         if (!hold) begin
            ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
         end
         // Same owner as last cycle extends the run; a full run restarts at 1.
         if (state_q != StIdle && win_idx == owner_q) begin
            cnt_d = (cnt_q == MAX_CNT) ? CNT_W'(1) : cnt_q + 1'b1;
         end else begin
            cnt_d = CNT_W'(1);
         end
      end
   end

   always_comb begin
      gnt     = '0;
      cand    = req;
      others  = req;
      idx     = '0;
      win_idx = '0;
      hold    = 1'b0;
      found   = 1'b0;
      if (!rst) begin
         others[owner_q] = 1'b0;
         if (state_q == StLocked && req[owner_q] && lock[owner_q]) begin
            if (cnt_q < MAX_CNT || others == '0) begin
               hold = 1'b1;
            end else begin
               cand[owner_q] = 1'b0;
            end
         end
         if (hold) begin
            found   = 1'b1;
            win_idx = owner_q;
         end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
               idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
               if (!found && cand[idx]) begin
                  found   = 1'b1;
                  win_idx = idx;
               end
            end
         end
         if (found) begin
            gnt[win_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      rom_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            rom_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   assign rom_en = |gnt;
   assign rvalid = rvalid_q;
   assign rdata  = rom_dout;

endmodule

// File: tb/tb_rr_rom_arbiter.sv
// Self-checking bench for rr_rom_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration model.
module tb_rr_rom_arbiter;

   localparam int NUM_REQ   = 3;
   localparam int AW        = 16;
   localparam int DW        = 12;
   localparam int MAX_BURST = 4;
   localparam int BOUND     = (NUM_REQ - 1) * MAX_BURST + 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    lock;
   logic [NUM_REQ*AW-1:0] addr;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    rvalid;
   logic [DW-1:0]         rdata;
   logic                  rom_en;
   logic [AW-1:0]         rom_addr;
   logic [DW-1:0]         rom_dout;

   int n_checks = 0;
   int n_pass   = 0;

   int m_ptr, m_owner, m_run;
   bit m_locked;

   rr_rom_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .lock    (lock),
      .addr    (addr),
      .gnt     (gnt),
      .rvalid  (rvalid),
      .rdata   (rdata),
      .rom_en  (rom_en),
      .rom_addr(rom_addr),
      .rom_dout(rom_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      if (a == 16'h0123) return 12'hABC;
      return a[11:0] ^ {a[15:12], a[15:8]};
   endfunction

   // Synchronous ROM with one-cycle latency.
   always_ff @(posedge clk) begin
      if (rom_en) rom_dout <= rom_f(rom_addr);
   end

   function automatic bit bit_at(input logic [NUM_REQ-1:0] v, input int i);
      logic [1:0] k;
      k = i[1:0];
      return v[k];
   endfunction

   function automatic int model_pick(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                                     output bit held);
      bit others;
      int skip;
      held = 1'b0;
      skip = -1;
      if (m_locked && m_owner >= 0 && bit_at(r, m_owner) && bit_at(l, m_owner)) begin
         others = 1'b0;
         for (int k = 0; k < NUM_REQ; k++) if (k != m_owner && bit_at(r, k)) others = 1'b1;
         if (m_run < MAX_BURST || !others) begin
            held = 1'b1;
            return m_owner;
         end
         skip = m_owner;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         int c;
         c = (m_ptr + k) % NUM_REQ;
         if (c != skip && bit_at(r, c)) return c;
      end
      return -1;
   endfunction

   function automatic void model_commit(input int w, input bit held, input logic [NUM_REQ-1:0] l);
      if (w < 0) begin
         m_owner = -1; m_run = 0; m_locked = 1'b0;
      end else begin
         m_run = (w == m_owner) ? ((m_run == MAX_BURST) ? 1 : m_run + 1) : 1;
         if (!held) m_ptr = (w + 1) % NUM_REQ;
         m_locked = bit_at(l, w);
         m_owner  = w;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; lock = '0; addr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_ptr = 0; m_owner = -1; m_run = 0; m_locked = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 3'b111; lock = 3'b111; addr = {16'h3333, 16'h2222, 16'h1111};
      #3;
      n_checks++;
      if ({gnt, rvalid, rom_en, rom_addr} !== '0)
         $display("FAIL reset_outputs: gnt=%b rvalid=%b rom_en=%b rom_addr=%h want all zero",
                  gnt, rvalid, rom_en, rom_addr);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({gnt, rvalid, rom_en, rom_addr} !== '0)
         $display("FAIL reset_clocked: gnt=%b rvalid=%b rom_en=%b rom_addr=%h want all zero",
                  gnt, rvalid, rom_en, rom_addr);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      addr = {16'hBEEF, 16'h0123, 16'h4444};
      req  = 3'b010;
      @(negedge clk);
      n_checks++;
      if (gnt !== 3'b010 || rom_addr !== 16'h0123 || rom_en !== 1'b1)
         $display("FAIL single_grant: gnt=%b addr=%h en=%b want 010/0123/1", gnt, rom_addr, rom_en);
      else n_pass++;
      tick();
      req = '0;
      @(negedge clk);
      n_checks++;
      if (rvalid !== 3'b010 || rdata !== 12'hABC || gnt !== 3'b000)
         $display("FAIL single_rdata: rvalid=%b rdata=%h gnt=%b want 010/abc/000",
                  rvalid, rdata, gnt);
      else n_pass++;
   endtask

   task automatic test_rotation();
      logic [NUM_REQ-1:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
      logic [NUM_REQ-1:0] prev;
      do_reset();
      req  = 3'b111;
      prev = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== exp_g[c] || rvalid !== prev)
            $display("FAIL rotation_%0d: gnt=%b rvalid=%b want %b/%b", c, gnt, rvalid, exp_g[c], prev);
         else n_pass++;
         prev = exp_g[c];
         tick();
      end
   endtask

   task automatic test_lock_burst();
      logic [NUM_REQ-1:0] exp_g [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
      do_reset();
      req  = 3'b011;
      lock = 3'b001;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt !== exp_g[c])
            $display("FAIL lock_burst_%0d: gnt=%b want %b", c, gnt, exp_g[c]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_lock_alone();
      int bad;
      do_reset();
      req  = 3'b100;
      lock = 3'b100;
      bad  = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (gnt !== 3'b100) bad++;
         tick();
      end
      n_checks++;
      if (bad != 0) $display("FAIL lock_alone: %0d cycles without gnt=100, want 0", bad);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      req  = 3'b011;
      lock = 3'b001;
      tick();
      tick();
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (gnt !== '0 || rvalid !== '0 || rom_en !== 1'b0)
         $display("FAIL async_reset: gnt=%b rvalid=%b rom_en=%b want 000/000/0", gnt, rvalid, rom_en);
      else n_pass++;
      tick();
      rst  = 1'b0;
      req  = 3'b110;
      lock = '0;
      @(negedge clk);
      n_checks++;
      if (gnt !== 3'b010) $display("FAIL post_reset_grant: gnt=%b want 010", gnt);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      logic [NUM_REQ-1:0] pend, eg, prev_g;
      logic [AW-1:0]      ea, prev_a;
      int                 wait_c [NUM_REQ];
      int                 w;
      bit                 held;
      do_reset();
      pend = '0; prev_g = '0; prev_a = '0;
      for (int i = 0; i < NUM_REQ; i++) wait_c[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req[i]  = pend[i] | ($urandom_range(0, 2) == 0);
            lock[i] = ($urandom_range(0, 3) != 0);
         end
         addr = {16'($urandom), 16'($urandom), 16'($urandom)};
         w  = model_pick(req, lock, held);
         eg = (w >= 0) ? 3'(3'b001 << w) : '0;
         ea = (w >= 0) ? addr[w*AW +: AW] : '0;
         @(negedge clk);
         n_checks++;
         if (gnt !== eg || rom_addr !== ea || rom_en !== (w >= 0))
            $display("FAIL rand_grant c=%0d: gnt=%b addr=%h en=%b want %b/%h/%b",
                     c, gnt, rom_addr, rom_en, eg, ea, (w >= 0));
         else n_pass++;
         n_checks++;
         if (rvalid !== prev_g || (prev_g != '0 && rdata !== rom_f(prev_a)))
            $display("FAIL rand_rvalid c=%0d: rvalid=%b rdata=%h want %b/%h",
                     c, rvalid, rdata, prev_g, rom_f(prev_a));
         else n_pass++;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bit_at(eg, i)) begin
               n_checks++;
               if (wait_c[i] > BOUND)
                  $display("FAIL rand_fair r%0d: waited %0d want <= %0d", i, wait_c[i], BOUND);
               else n_pass++;
               wait_c[i] = 0;
            end else if (bit_at(req, i)) begin
               wait_c[i]++;
            end
         end
         pend   = req & ~eg;
         prev_g = eg;
         prev_a = ea;
         tick();
         model_commit(w, held, lock);
      end
   endtask

   initial begin
      rst = 1'b1; req = '0; lock = '0; addr = '0;
      test_reset();
      test_single();
      test_rotation();
      test_lock_burst();
      test_lock_alone();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
